// File: rtl/core_quant_pkg.sv
// Shared definitions for the multi-lane requantiser: rounding-mode encodings
// and the intermediate product width helper.
package core_quant_pkg;

  localparam logic [1:0] RND_TRUNC     = 2'd0;
  localparam logic [1:0] RND_HALF_UP   = 2'd1;
  localparam logic [1:0] RND_HALF_EVEN = 2'd2;

  function automatic int unsigned temp_bit(input int unsigned idata_width,
                                           input int unsigned scale_width);
    return idata_width + scale_width;
  endfunction

endpackage

// File: rtl/core_quant_lane.sv
// One requantiser lane: scale multiply, retime, bias + round bits, shift + round,
// saturate. Each stage register loads only when the pipe advances and its upstream beat is valid.
module core_quant_lane
  import core_quant_pkg::*;
#(
  parameter int unsigned IDATA_WIDTH       = 25,
  parameter int unsigned ODATA_BIT         = 8,
  parameter int unsigned CDATA_SCALE_WIDTH = 10,
  parameter int unsigned CDATA_BIAS_WIDTH  = 16,
  parameter int unsigned CDATA_SHIFT_WIDTH = 5,
  parameter int unsigned MUL_RETIME        = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [MUL_RETIME+3:0]        up_vld,
  input  logic [CDATA_SCALE_WIDTH-1:0] scale,
  input  logic [CDATA_BIAS_WIDTH-1:0]  bias,
  input  logic [CDATA_SHIFT_WIDTH-1:0] shift,
  input  logic [1:0]                   round_mode,
  input  logic                         out_unsigned,
  input  logic [IDATA_WIDTH-1:0]       idata,
  output logic [ODATA_BIT-1:0]         odata,
  output logic                         odata_sat
);

  localparam int unsigned TB       = temp_bit(IDATA_WIDTH, CDATA_SCALE_WIDTH);
  localparam int unsigned BW       = TB + 1;
  localparam int unsigned ST_BIAS  = MUL_RETIME + 1;
  localparam int unsigned ST_SHIFT = MUL_RETIME + 2;
  localparam int unsigned ST_SAT   = MUL_RETIME + 3;

  localparam int SMAX_I = (1 << (ODATA_BIT - 1)) - 1;
  localparam int SMIN_I = -SMAX_I - 1;
  localparam int UMAX_I = (1 << ODATA_BIT) - 1;
  localparam logic signed [BW-1:0] SMAX = BW'(SMAX_I);
  localparam logic signed [BW-1:0] SMIN = BW'(SMIN_I);
  localparam logic signed [BW-1:0] UMAX = BW'(UMAX_I);
  localparam logic [CDATA_SHIFT_WIDTH-1:0] SH_ONE = CDATA_SHIFT_WIDTH'(1);

  logic [MUL_RETIME+3:0] ld;
  assign ld = up_vld & {(MUL_RETIME + 4){en}};

  // Scale is unsigned, so it is zero-extended before the signed multiply
  logic signed [TB-1:0] prod_c;
  assign prod_c = $signed(TB'($signed(idata))) * $signed(TB'(scale));

  logic signed [TB-1:0] mp_q [MUL_RETIME+1];
  logic signed [TB-1:0] mp_d [MUL_RETIME+1];

  assign mp_d[0] = ld[0] ? prod_c : mp_q[0];
  for (genvar j = 1; j <= MUL_RETIME; j++) begin : g_rt
    assign mp_d[j] = ld[j] ? mp_q[j-1] : mp_q[j];
  end

  // Bias add, round bit b[shift-1] and sticky OR of b[shift-2:0]
  logic signed [BW-1:0] b_c, b_d, b_q;
  logic [BW-1:0]        rbit_c;
  logic                 r_c, r_d, r_q, st_c, st_d, st_q;

  assign b_c    = BW'(mp_q[MUL_RETIME]) + BW'($signed(bias));
  assign rbit_c = BW'(1) << (shift - SH_ONE);
  assign r_c    = (shift != '0) && (|(b_c & rbit_c));
  assign st_c   = (shift != '0) && (|(b_c & (rbit_c - BW'(1))));

  always_comb begin
    b_d  = b_q;
    r_d  = r_q;
    st_d = st_q;
    if (ld[ST_BIAS]) begin
      b_d  = b_c;
      r_d  = r_c;
      st_d = st_c;
    end
  end

  logic signed [BW-1:0] sh_c, s_c, s_d, s_q;
  logic                 inc_c;

  assign sh_c = b_q >>> shift;

  always_comb begin
    inc_c = 1'b0;
    case (round_mode)
      RND_HALF_UP:   inc_c = r_q;
      RND_HALF_EVEN: inc_c = r_q & (st_q | sh_c[0]);
      default:       inc_c = 1'b0;
    endcase
  end

  assign s_c = sh_c + BW'(inc_c);
  assign s_d = ld[ST_SHIFT] ? s_c : s_q;

  logic [ODATA_BIT-1:0] od_d, od_q;
  logic                 sat_d, sat_q;

  always_comb begin
    od_d  = od_q;
    sat_d = sat_q;
    if (ld[ST_SAT]) begin
      od_d  = ODATA_BIT'(s_q);
      sat_d = 1'b0;
      if (out_unsigned) begin
        if (s_q < 0) begin
          od_d  = '0;
          sat_d = 1'b1;
        end else if (s_q > UMAX) begin
          od_d  = ODATA_BIT'(UMAX_I);
          sat_d = 1'b1;
        end
      end else begin
        if (s_q > SMAX) begin
          od_d  = ODATA_BIT'(SMAX_I);
          sat_d = 1'b1;
        end else if (s_q < SMIN) begin
          od_d  = ODATA_BIT'(SMIN_I);
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mp_q  <= '{default: '0};
      b_q   <= '0;
      r_q   <= 1'b0;
      st_q  <= 1'b0;
      s_q   <= '0;
      od_q  <= '0;
      sat_q <= 1'b0;
    end else begin
      mp_q  <= mp_d;
      b_q   <= b_d;
      r_q   <= r_d;
      st_q  <= st_d;
      s_q   <= s_d;
      od_q  <= od_d;
      sat_q <= sat_d;
    end
  end

  assign odata     = od_q;
  assign odata_sat = sat_q;

endmodule

// File: rtl/core_quant_mc.sv
// Multi-lane requantiser top: LANES datapath lanes sharing one valid chain,
// a global stall enable, busy flag and a sticky saturation event counter.
module core_quant_mc
  import core_quant_pkg::*;
#(
  parameter int unsigned LANES             = 4,
  parameter int unsigned IDATA_WIDTH       = 25,
  parameter int unsigned ODATA_BIT         = 8,
  parameter int unsigned CDATA_SCALE_WIDTH = 10,
  parameter int unsigned CDATA_BIAS_WIDTH  = 16,
  parameter int unsigned CDATA_SHIFT_WIDTH = 5,
  parameter int unsigned MUL_RETIME        = 3,
  parameter int unsigned SAT_CNT_WIDTH     = 16
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [LANES*CDATA_SCALE_WIDTH-1:0]   cfg_quant_scale,
  input  logic [LANES*CDATA_BIAS_WIDTH-1:0]    cfg_quant_bias,
  input  logic [LANES*CDATA_SHIFT_WIDTH-1:0]   cfg_quant_shift,
  input  logic [1:0]                           cfg_round_mode,
  input  logic                                 cfg_out_unsigned,
  input  logic                                 cfg_sat_clr,
  input  logic [LANES*IDATA_WIDTH-1:0]         idata,
  input  logic                                 idata_valid,
  output logic                                 idata_ready,
  output logic [LANES*ODATA_BIT-1:0]           odata,
  output logic                                 odata_valid,
  input  logic                                 odata_ready,
  output logic [LANES-1:0]                     odata_sat,
  output logic [SAT_CNT_WIDTH-1:0]             sat_cnt,
  output logic                                 busy
);

  localparam int unsigned NSTG = MUL_RETIME + 4;

  logic [NSTG-1:0] vld_q, vld_d, up_vld_c;
  logic            en_c;

  // Whole pipe advances whenever the output slot is empty or being drained
  assign en_c     = ~vld_q[NSTG-1] | odata_ready;
  assign up_vld_c = {vld_q[NSTG-2:0], idata_valid};

  always_comb begin
    vld_d = vld_q;
    if (en_c) vld_d = up_vld_c;
  end

  logic                     busy_d, busy_q;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_d, sat_cnt_q;

  assign busy_d = |vld_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (cfg_sat_clr)
      sat_cnt_d = '0;
    else if (vld_q[NSTG-1] && odata_ready && (|odata_sat) && (sat_cnt_q != '1))
      sat_cnt_d = sat_cnt_q + SAT_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q     <= '0;
      busy_q    <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    core_quant_lane #(
      .IDATA_WIDTH      (IDATA_WIDTH),
      .ODATA_BIT        (ODATA_BIT),
      .CDATA_SCALE_WIDTH(CDATA_SCALE_WIDTH),
      .CDATA_BIAS_WIDTH (CDATA_BIAS_WIDTH),
      .CDATA_SHIFT_WIDTH(CDATA_SHIFT_WIDTH),
      .MUL_RETIME       (MUL_RETIME)
    ) u_lane (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en_c),
      .up_vld      (up_vld_c),
      .scale       (cfg_quant_scale[i*CDATA_SCALE_WIDTH +: CDATA_SCALE_WIDTH]),
      .bias        (cfg_quant_bias[i*CDATA_BIAS_WIDTH +: CDATA_BIAS_WIDTH]),
      .shift       (cfg_quant_shift[i*CDATA_SHIFT_WIDTH +: CDATA_SHIFT_WIDTH]),
      .round_mode  (cfg_round_mode),
      .out_unsigned(cfg_out_unsigned),
      .idata       (idata[i*IDATA_WIDTH +: IDATA_WIDTH]),
      .odata       (odata[i*ODATA_BIT +: ODATA_BIT]),
      .odata_sat   (odata_sat[i])
    );
  end

  assign idata_ready = en_c;
  assign odata_valid = vld_q[NSTG-1];
  assign busy        = busy_q;
  assign sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_core_quant_mc.sv
// Scoreboard bench for core_quant_mc: directed beats push hand-computed
// expectations, a negedge monitor pops and compares on every output transfer.
module tb_core_quant_mc;

  localparam int LANES = 4;
  localparam int IW    = 25;
  localparam int OB    = 8;
  localparam int SCW   = 10;
  localparam int BIW   = 16;
  localparam int SHW   = 5;
  localparam int CW    = 4;

  typedef struct packed {
    logic [LANES*OB-1:0] od;
    logic [LANES-1:0]    sat;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic [LANES*SCW-1:0]     cfg_quant_scale;
  logic [LANES*BIW-1:0]     cfg_quant_bias;
  logic [LANES*SHW-1:0]     cfg_quant_shift;
  logic [1:0]               cfg_round_mode;
  logic                     cfg_out_unsigned;
  logic                     cfg_sat_clr;
  logic [LANES*IW-1:0]      idata;
  logic                     idata_valid;
  logic                     idata_ready;
  logic [LANES*OB-1:0]      odata;
  logic                     odata_valid;
  logic                     odata_ready;
  logic [LANES-1:0]         odata_sat;
  logic [CW-1:0]            sat_cnt;
  logic                     busy;

  core_quant_mc #(.SAT_CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .cfg_quant_scale (cfg_quant_scale),
    .cfg_quant_bias  (cfg_quant_bias),
    .cfg_quant_shift (cfg_quant_shift),
    .cfg_round_mode  (cfg_round_mode),
    .cfg_out_unsigned(cfg_out_unsigned),
    .cfg_sat_clr     (cfg_sat_clr),
    .idata           (idata),
    .idata_valid     (idata_valid),
    .idata_ready     (idata_ready),
    .odata           (odata),
    .odata_valid     (odata_valid),
    .odata_ready     (odata_ready),
    .odata_sat       (odata_sat),
    .sat_cnt         (sat_cnt),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   rx_cnt = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: handshake rule every cycle, payload on every output transfer
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      chk("idata_ready_rule", idata_ready, !(odata_valid && !odata_ready));
      if (odata_valid && odata_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got odata 0x%0h with empty scoreboard", odata);
        end else begin
          e = sb.pop_front();
          chk("odata", odata, e.od);
          chk("odata_sat", odata_sat, e.sat);
          rx_cnt++;
        end
      end
    end
  end

  function automatic exp_t ex(input logic [7:0] v, input logic s);
    exp_t e;
    e.od  = {LANES{v}};
    e.sat = {LANES{s}};
    return e;
  endfunction

  task automatic send(input logic [LANES*IW-1:0] d, input exp_t e);
    logic acc;
    acc         = 1'b0;
    idata       = d;
    idata_valid = 1'b1;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = idata_ready;
      if (acc) sb.push_back(e);
      @(posedge clk);
      #1;
    end
    idata_valid = 1'b0;
    chk("accept", acc, 1'b1);
  endtask

  task automatic send1(input int v, input logic [7:0] ev, input logic es);
    logic [IW-1:0] w;
    w = IW'(v);
    send({LANES{w}}, ex(ev, es));
  endtask

  task automatic drain();
    int n;
    n = 0;
    odata_ready = 1'b1;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_idle", {busy, sb.size() != 0}, 2'b00);
  endtask

  task automatic set_cfg(input int sc, input int bi, input int sh,
                         input logic [1:0] md, input logic uns);
    logic [SCW-1:0] s;
    logic [BIW-1:0] b;
    logic [SHW-1:0] h;
    drain();
    s = SCW'(sc);
    b = BIW'(bi);
    h = SHW'(sh);
    cfg_quant_scale  = {LANES{s}};
    cfg_quant_bias   = {LANES{b}};
    cfg_quant_shift  = {LANES{h}};
    cfg_round_mode   = md;
    cfg_out_unsigned = uns;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LANES*IW-1:0] d;
    exp_t                e;
    logic                seen;
    rstn             = 1'b0;
    cfg_sat_clr      = 1'b0;
    idata            = '0;
    idata_valid      = 1'b0;
    odata_ready      = 1'b1;
    cfg_quant_scale  = '0;
    cfg_quant_bias   = '0;
    cfg_quant_shift  = '0;
    cfg_round_mode   = 2'd0;
    cfg_out_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    chk("rst_odata_valid", odata_valid, 1'b0);
    chk("rst_odata", odata, '0);
    chk("rst_odata_sat", odata_sat, '0);
    chk("rst_sat_cnt", sat_cnt, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idata_ready", idata_ready, 1'b1);

    // Rounding modes, b = 306 and b = 102
    set_cfg(3, 6, 2, 2'd0, 1'b0); send1(100, 8'd76, 1'b0);
    set_cfg(3, 6, 2, 2'd1, 1'b0); send1(100, 8'd77, 1'b0);
    set_cfg(3, 6, 2, 2'd2, 1'b0); send1(100, 8'd76, 1'b0);
    set_cfg(1, 0, 2, 2'd2, 1'b0); send1(102, 8'd26, 1'b0);
    set_cfg(1, 0, 1, 2'd1, 1'b0); send1(-7, 8'hFD, 1'b0);
    set_cfg(1, 0, 1, 2'd2, 1'b0); send1(-7, 8'hFC, 1'b0);
    set_cfg(1, 0, 1, 2'd3, 1'b0); send1(-7, 8'hFC, 1'b0);
    set_cfg(1000, 0, 13, 2'd1, 1'b0); send1(1000, 8'h7A, 1'b0);
    set_cfg(1, -20, 0, 2'd0, 1'b0); send1(10, 8'hF6, 1'b0);
    drain();

    // Signed saturation and counter increments
    set_cfg(1, 0, 0, 2'd0, 1'b0);
    cfg_sat_clr = 1'b1; @(posedge clk); #1 cfg_sat_clr = 1'b0;
    chk("sat_cnt_cleared", sat_cnt, 4'd0);
    send1(1000, 8'h7F, 1'b1);  drain(); chk("sat_cnt_1", sat_cnt, 4'd1);
    send1(-1000, 8'h80, 1'b1); drain(); chk("sat_cnt_2", sat_cnt, 4'd2);
    send1(5, 8'h05, 1'b0);     drain(); chk("sat_cnt_hold", sat_cnt, 4'd2);

    // Unsigned clamping
    set_cfg(1, 0, 0, 2'd0, 1'b1);
    send1(-5, 8'h00, 1'b1);
    send1(300, 8'hFF, 1'b1);
    send1(200, 8'hC8, 1'b0);
    drain();
    chk("sat_cnt_uns", sat_cnt, 4'd4);

    // Backpressure: 20 beats, lane i carries k+20*i
    set_cfg(1, 0, 0, 2'd0, 1'b0);
    rx_cnt = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          for (int i = 0; i < LANES; i++) begin
            d[i*IW +: IW]  = IW'(k + 20 * i);
            e.od[i*OB +: OB] = OB'(k + 20 * i);
          end
          e.sat = '0;
          send(d, e);
        end
      end
      begin
        for (int c = 0; c < 70; c++) begin
          @(posedge clk);
          #1;
          if (c >= 8 && c < 15) odata_ready = 1'b0;
          else odata_ready = ($urandom_range(0, 2) != 0);
        end
        odata_ready = 1'b1;
      end
    join
    drain();
    chk("bp_beats_received", rx_cnt, 20);

    // Counter sticks at all-ones
    for (int k = 0; k < 13; k++) send1(1000, 8'h7F, 1'b1);
    drain();
    chk("sat_cnt_stick", sat_cnt, 4'hF);

    // Clear coincident with a saturating transfer wins
    odata_ready = 1'b0;
    send1(-1000, 8'h80, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = odata_valid;
    end
    chk("stalled_output_present", seen, 1'b1);
    odata_ready = 1'b1;
    cfg_sat_clr = 1'b1;
    @(posedge clk);
    #1 cfg_sat_clr = 1'b0;
    chk("sat_cnt_clr_priority", sat_cnt, 4'd0);
    send1(1000, 8'h7F, 1'b1); drain();
    chk("sat_cnt_after_clr", sat_cnt, 4'd1);

    // Reset with 5 beats in flight
    for (int k = 0; k < 5; k++) send1(k + 1, 8'(k + 1), 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_odata_valid", odata_valid, 1'b0);
    chk("mid_rst_odata", odata, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sat_cnt", sat_cnt, '0);
    sb.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("post_rst_busy", busy, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      seen = seen | odata_valid;
    end
    chk("no_output_after_rst", seen, 1'b0);
    @(posedge clk);
    #1;
    rx_cnt = 0;
    send1(42, 8'd42, 1'b0);
    drain();
    chk("post_rst_beat", rx_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
